// File: rtl/img_proc_pkg.sv
// Shared constants and types for the image-processing datapath blocks.
package img_proc_pkg;

  localparam int PIX_W       = 8;
  localparam int SOBEL_SUM_W = 10;
  localparam int SOBEL_MAG_W = 11;

  localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

  typedef logic [PIX_W-1:0]       pix_t;
  typedef logic [SOBEL_SUM_W-1:0] sobel_sum_t;

  typedef struct packed {
    sobel_sum_t gx_p;
    sobel_sum_t gx_n;
    sobel_sum_t gy_p;
    sobel_sum_t gy_n;
  } sobel_sums_t;

endpackage

// File: rtl/sobel_abs_diff.sv
// Registered absolute difference |a-b| of two unsigned operands.
module sobel_abs_diff
  import img_proc_pkg::*;
#(
  parameter int DATA_W = SOBEL_SUM_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] abs_q
);

  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] diff_abs;

  // One extra bit keeps the sign; |diff| of two DATA_W-bit values always fits DATA_W bits.
  assign diff     = $signed({1'b0, a}) - $signed({1'b0, b});
  assign diff_abs = diff[DATA_W] ? -diff : diff;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      abs_q <= '0;
    end else begin
      abs_q <= diff_abs[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/sobel_edge_detect_8bit.sv
// Sobel gradient magnitude, saturation and threshold on a 3x3 window stream (4-stage pipeline),
// with per-frame output pixel counting.
module sobel_edge_detect_8bit
  import img_proc_pkg::*;
#(
  parameter int PIC_PIX_MAX = 'd7,
  parameter bit EDGE_MODE   = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       matrix_wr_en,
  input  logic [7:0] matrix_p11,
  input  logic [7:0] matrix_p12,
  input  logic [7:0] matrix_p13,
  input  logic [7:0] matrix_p21,
  input  logic [7:0] matrix_p22,
  input  logic [7:0] matrix_p23,
  input  logic [7:0] matrix_p31,
  input  logic [7:0] matrix_p32,
  input  logic [7:0] matrix_p33,
  input  logic [7:0] threshold,
  output logic       post_wr_en,
  output logic [7:0] post_data,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(PIC_PIX_MAX + 1);

  function automatic sobel_sum_t tap_sum(pix_t a, pix_t b, pix_t c);
    return SOBEL_SUM_W'(a) + (SOBEL_SUM_W'(b) << 1) + SOBEL_SUM_W'(c);
  endfunction

  function automatic pix_t sat_mag(logic [SOBEL_MAG_W-1:0] m);
    return (|m[SOBEL_MAG_W-1:PIX_W]) ? {PIX_W{1'b1}} : m[PIX_W-1:0];
  endfunction

  // The centre pixel carries no Sobel weight.
  logic unused_ok;
  assign unused_ok = ^matrix_p22;

  sobel_sums_t           sums_p1;
  logic                  vld_p1;
  sobel_sum_t            gx_abs_p2;
  sobel_sum_t            gy_abs_p2;
  logic                  vld_p2;
  logic [SOBEL_MAG_W-1:0] mag_sum;
  pix_t                  mag_p3;
  logic                  vld_p3;
  logic [CNT_W-1:0]      pix_cnt;
  logic                  last_pix;

  // Stage 1: weighted column/row partial sums
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p1  <= 1'b0;
      sums_p1 <= '0;
    end else begin
      vld_p1 <= matrix_wr_en;
      if (matrix_wr_en) begin
        sums_p1.gx_p <= tap_sum(matrix_p13, matrix_p23, matrix_p33);
        sums_p1.gx_n <= tap_sum(matrix_p11, matrix_p21, matrix_p31);
        sums_p1.gy_p <= tap_sum(matrix_p31, matrix_p32, matrix_p33);
        sums_p1.gy_n <= tap_sum(matrix_p11, matrix_p12, matrix_p13);
      end
    end
  end

  // Stage 2: absolute gradients
  sobel_abs_diff #(.DATA_W(SOBEL_SUM_W)) u_abs_gx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a         (sums_p1.gx_p),
    .b         (sums_p1.gx_n),
    .abs_q     (gx_abs_p2)
  );

  sobel_abs_diff #(.DATA_W(SOBEL_SUM_W)) u_abs_gy (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a         (sums_p1.gy_p),
    .b         (sums_p1.gy_n),
    .abs_q     (gy_abs_p2)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
    end
  end

  // Stage 3: L1 magnitude, saturated to a pixel
  assign mag_sum = {1'b0, gx_abs_p2} + {1'b0, gy_abs_p2};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p3 <= 1'b0;
      mag_p3 <= '0;
    end else begin
      vld_p3 <= vld_p2;
      mag_p3 <= sat_mag(mag_sum);
    end
  end

  // Stage 4: threshold / output register and frame pixel counter
  assign last_pix = (pix_cnt == CNT_W'(PIC_PIX_MAX - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      post_wr_en <= 1'b0;
      post_data  <= '0;
      frame_done <= 1'b0;
      pix_cnt    <= '0;
    end else begin
      post_wr_en <= vld_p3;
      frame_done <= vld_p3 && last_pix;
      if (vld_p3) begin
        if (EDGE_MODE) begin
          post_data <= mag_p3;
        end else begin
          post_data <= (mag_p3 > threshold) ? EDGE_ON : EDGE_OFF;
        end
        pix_cnt <= last_pix ? '0 : pix_cnt + CNT_W'(1);
      end
    end
  end

endmodule
